// File: rtl/mips_pipe_pkg.sv
// -----------------------------------------------------------------------------
// mips_pipe_pkg
// Shared constants for the MIPS pipeline control blocks.
//   ST_RUN / ST_LU_STALL / ST_HOLD : hazard controller FSM encodings
//   REG_ZERO                       : architectural $zero register index
//   CNT_W                          : width of the performance counters
//   load_use_hit()                 : load-use hazard decode between ID/EX and IF/ID
// -----------------------------------------------------------------------------
package mips_pipe_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_LU_STALL = 2'd1;
    localparam logic [1:0] ST_HOLD     = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int CNT_W = 32;

    // A load into $zero never produces a value, so it can never cause a hazard.
    function automatic logic load_use_hit(
        input logic       ex_mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       id_uses_rt
    );
        return ex_mem_read && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Event counter that sticks at all-ones instead of wrapping.
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset, clears the count
//   en_i     : count one event this cycle
//   clr_i    : synchronous clear (wins over en_i)
//   count_o  : current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller: load-use stalls, taken-branch flushes resolved in
// MEM, and whole-pipe freeze while data memory is busy. A branch that resolves
// during a freeze is remembered and replayed on the first non-busy cycle.
//
// Ports
//   clk, rst                      : clock, asynchronous active-high reset
//   IFtoID_Rs/Rt, ID_UsesRt       : source operands of the instruction in ID
//   IDtoEX_MemRead, IDtoEX_Rt     : load in EX and its destination register
//   MEM_Branch, MEM_BranchTarget  : taken-branch pulse and target from MEM
//   MEM_Busy                      : data memory wait request
//   PCWrite, IFtoID_Write         : register enables (1 = advance)
//   IDtoEX_Bubble                 : zero control fields entering ID/EX
//   IFtoID/IDtoEX/EXtoMEM_Flush   : synchronous clears of the pipe registers
//   Pipe_Hold                     : freeze all pipe registers
//   PCSrc_Branch, BranchTarget_Out: redirect fetch to the branch target
//   dbg_state_o                   : FSM state for observation
//
// Build option HAZARD_PERF_CNT_EN adds Stall_Count, Flush_Count, Hold_Count.
//
// Priority every cycle: MEM_Busy > branch (new or pending) > load-use.
// All control outputs are Mealy and are forced to 0 while rst is high.
// -----------------------------------------------------------------------------
module hazard_ctrl
    import mips_pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IFtoID_Rs,
    input  logic [4:0]       IFtoID_Rt,
    input  logic             ID_UsesRt,
    input  logic             IDtoEX_MemRead,
    input  logic [4:0]       IDtoEX_Rt,
    input  logic             MEM_Branch,
    input  logic [31:0]      MEM_BranchTarget,
    input  logic             MEM_Busy,
    output logic             PCWrite,
    output logic             IFtoID_Write,
    output logic             IDtoEX_Bubble,
    output logic             IFtoID_Flush,
    output logic             IDtoEX_Flush,
    output logic             EXtoMEM_Flush,
    output logic             Pipe_Hold,
    output logic             PCSrc_Branch,
    output logic [31:0]      BranchTarget_Out,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count,
    output logic [CNT_W-1:0] Hold_Count,
`endif
    output logic [1:0]       dbg_state_o
);

    logic [1:0]  state_q, state_d;
    logic        pend_q, pend_d;
    logic [31:0] tgt_q, tgt_d;
    logic        lu;

    assign lu = load_use_hit(IDtoEX_MemRead, IDtoEX_Rt, IFtoID_Rs, IFtoID_Rt, ID_UsesRt);

    always_comb begin
        state_d          = ST_RUN;
        pend_d           = pend_q;
        tgt_d            = tgt_q;
        PCWrite          = 1'b0;
        IFtoID_Write     = 1'b0;
        IDtoEX_Bubble    = 1'b0;
        IFtoID_Flush     = 1'b0;
        IDtoEX_Flush     = 1'b0;
        EXtoMEM_Flush    = 1'b0;
        Pipe_Hold        = 1'b0;
        PCSrc_Branch     = 1'b0;
        BranchTarget_Out = 32'd0;

        if (rst) begin
            pend_d = 1'b0;
            tgt_d  = 32'd0;
        end else if (MEM_Busy) begin
            Pipe_Hold = 1'b1;
            state_d   = ST_HOLD;
            // Remember the branch; the newest pulse in a hold wins.
            if (MEM_Branch) begin
                pend_d = 1'b1;
                tgt_d  = MEM_BranchTarget;
            end
        end else if (MEM_Branch || pend_q) begin
            IFtoID_Flush     = 1'b1;
            IDtoEX_Flush     = 1'b1;
            EXtoMEM_Flush    = 1'b1;
            PCSrc_Branch     = 1'b1;
            PCWrite          = 1'b1;
            BranchTarget_Out = MEM_Branch ? MEM_BranchTarget : tgt_q;
            pend_d           = 1'b0;
            state_d          = ST_RUN;
        end else if (lu && (state_q != ST_LU_STALL)) begin
            // The bubble enters EX next cycle, so one stall per load suffices.
            IDtoEX_Bubble = 1'b1;
            state_d       = ST_LU_STALL;
        end else begin
            PCWrite      = 1'b1;
            IFtoID_Write = 1'b1;
            state_d      = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            pend_q  <= 1'b0;
            tgt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            tgt_q   <= tgt_d;
        end
    end

    assign dbg_state_o = state_q;

`ifdef HAZARD_PERF_CNT_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (IDtoEX_Bubble),
        .clr_i   (1'b0),
        .count_o (Stall_Count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (PCSrc_Branch),
        .clr_i   (1'b0),
        .count_o (Flush_Count)
    );

    sat_counter #(.W(CNT_W)) u_hold_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (Pipe_Hold),
        .clr_i   (1'b0),
        .count_o (Hold_Count)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed scenarios followed by randomized traffic, checked against a
// behavioural model of the hazard rules. Define HAZARD_PERF_CNT_EN to also
// check the performance counters including saturation.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  IFtoID_Rs, IFtoID_Rt, IDtoEX_Rt;
    logic        ID_UsesRt, IDtoEX_MemRead, MEM_Branch, MEM_Busy;
    logic [31:0] MEM_BranchTarget;
    logic        PCWrite, IFtoID_Write, IDtoEX_Bubble;
    logic        IFtoID_Flush, IDtoEX_Flush, EXtoMEM_Flush;
    logic        Pipe_Hold, PCSrc_Branch;
    logic [31:0] BranchTarget_Out;
    logic [1:0]  dbg_state;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] Stall_Count, Flush_Count, Hold_Count;
`endif

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    hazard_ctrl u_dut (
        .clk              (clk),
        .rst              (rst),
        .IFtoID_Rs        (IFtoID_Rs),
        .IFtoID_Rt        (IFtoID_Rt),
        .ID_UsesRt        (ID_UsesRt),
        .IDtoEX_MemRead   (IDtoEX_MemRead),
        .IDtoEX_Rt        (IDtoEX_Rt),
        .MEM_Branch       (MEM_Branch),
        .MEM_BranchTarget (MEM_BranchTarget),
        .MEM_Busy         (MEM_Busy),
        .PCWrite          (PCWrite),
        .IFtoID_Write     (IFtoID_Write),
        .IDtoEX_Bubble    (IDtoEX_Bubble),
        .IFtoID_Flush     (IFtoID_Flush),
        .IDtoEX_Flush     (IDtoEX_Flush),
        .EXtoMEM_Flush    (EXtoMEM_Flush),
        .Pipe_Hold        (Pipe_Hold),
        .PCSrc_Branch     (PCSrc_Branch),
        .BranchTarget_Out (BranchTarget_Out),
`ifdef HAZARD_PERF_CNT_EN
        .Stall_Count      (Stall_Count),
        .Flush_Count      (Flush_Count),
        .Hold_Count       (Hold_Count),
`endif
        .dbg_state_o      (dbg_state)
    );

    // ---------------- scoreboard ----------------
    // Expected entry: {PCWrite, IFtoID_Write, Bubble, IF/ID flush, ID/EX flush,
    //                  EX/MEM flush, Pipe_Hold, PCSrc_Branch, target[31:0]}
    logic [39:0] exp_q[$];
    int n_checks = 0;
    int n_bad    = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_stalled: the previous cycle was a load-use stall (the load now sits
    // behind a bubble, so the same dependency must not stall again).
    logic        m_pend;
    logic [31:0] m_tgt;
    logic        m_stalled;
    logic [31:0] m_stall_cnt, m_flush_cnt, m_hold_cnt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_reset();
        m_pend      = 1'b0;
        m_tgt       = 32'd0;
        m_stalled   = 1'b0;
        m_stall_cnt = 32'd0;
        m_flush_cnt = 32'd0;
        m_hold_cnt  = 32'd0;
    endtask

    task automatic check_outputs(input string tag);
        logic [39:0] e;
        logic [7:0]  obs, mask;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_queue_empty"}, 32'd1, 32'd0);
            return;
        end
        e   = exp_q.pop_front();
        obs = {PCWrite, IFtoID_Write, IDtoEX_Bubble, IFtoID_Flush, IDtoEX_Flush,
               EXtoMEM_Flush, Pipe_Hold, PCSrc_Branch};
        // IF/ID write enable is irrelevant while IF/ID is being flushed.
        mask = e[32] ? 8'hBF : 8'hFF;
        check_eq({tag, "_ctl"}, {24'd0, obs & mask}, {24'd0, e[39:32] & mask});
        check_eq({tag, "_tgt"}, BranchTarget_Out, e[31:0]);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic busy, input logic br, input logic [31:0] tgt,
                         input logic mr, input logic [4:0] ex_rt, input logic [4:0] rs,
                         input logic [4:0] rt, input logic uses);
        MEM_Busy         = busy;
        MEM_Branch       = br;
        MEM_BranchTarget = tgt;
        IDtoEX_MemRead   = mr;
        IDtoEX_Rt        = ex_rt;
        IFtoID_Rs        = rs;
        IFtoID_Rt        = rt;
        ID_UsesRt        = uses;
    endtask

    // One clock cycle: drive, predict, check at negedge, advance model after posedge.
    task automatic step(input string tag, input logic busy, input logic br,
                        input logic [31:0] tgt, input logic mr, input logic [4:0] ex_rt,
                        input logic [4:0] rs, input logic [4:0] rt, input logic uses);
        logic        lu, hold, flush, stall, run;
        logic [31:0] tout;
        drive(busy, br, tgt, mr, ex_rt, rs, rt, uses);
        lu    = mr && (ex_rt != 5'd0) && ((ex_rt == rs) || (uses && (ex_rt == rt)));
        hold  = busy;
        flush = !busy && (br || m_pend);
        stall = !busy && !flush && lu && !m_stalled;
        run   = !hold && !flush && !stall;
        tout  = flush ? (br ? tgt : m_tgt) : 32'd0;
        exp_q.push_back({run | flush, run, stall, flush, flush, flush, hold, flush, tout});
        @(negedge clk);
        check_outputs(tag);
        @(posedge clk);
        #1;
        if (hold && br) begin
            m_pend = 1'b1;
            m_tgt  = tgt;
        end
        if (flush) m_pend = 1'b0;
        m_stalled = stall;
        if (stall) m_stall_cnt = sat_inc(m_stall_cnt);
        if (flush) m_flush_cnt = sat_inc(m_flush_cnt);
        if (hold)  m_hold_cnt  = sat_inc(m_hold_cnt);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        model_reset();
        for (int i = 0; i < cycles; i++) begin
            exp_q.push_back(40'd0);
            @(negedge clk);
            check_outputs("reset");
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic check_counters(input string tag);
        check_eq({tag, "_stall_cnt"}, Stall_Count, m_stall_cnt);
        check_eq({tag, "_flush_cnt"}, Flush_Count, m_flush_cnt);
        check_eq({tag, "_hold_cnt"},  Hold_Count,  m_hold_cnt);
    endtask
`endif

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        model_reset();
        #2;
        do_reset(2);

        idle("run0");

        // Load-use on rs: one stall, then suppressed, then normal flow.
        step("lu_rs",    1'b0, 1'b0, 32'd0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0);
        step("lu_again", 1'b0, 1'b0, 32'd0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0);
        idle("lu_after");

        // Rt match without rt use, and a load into $zero: no stall.
        step("lu_rt_unused", 1'b0, 1'b0, 32'd0, 1'b1, 5'd8, 5'd3, 5'd8, 1'b0);
        step("lu_rt_used",   1'b0, 1'b0, 32'd0, 1'b1, 5'd8, 5'd3, 5'd8, 1'b1);
        idle("lu_rt_after");
        step("lu_zero",      1'b0, 1'b0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1);

        // Immediate taken branch.
        step("br_now", 1'b0, 1'b1, 32'h0040_0020, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        idle("br_now_after");

        // Branch during a 3-cycle hold, replayed when memory frees up.
        step("hold1", 1'b1, 1'b1, 32'h0000_0100, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step("hold2", 1'b1, 1'b0, 32'h0000_0000, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step("hold3", 1'b1, 1'b0, 32'h0000_0000, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        idle("hold_replay");
        idle("hold_replay_after");

        // Later pulse in the same hold overwrites the remembered target.
        step("ovw1", 1'b1, 1'b1, 32'h0000_0200, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step("ovw2", 1'b1, 1'b1, 32'h0000_0300, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step("ovw_replay", 1'b0, 1'b0, 32'h0000_0000, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0);

        // Branch and load-use together: flush wins, no bubble.
        step("br_lu", 1'b0, 1'b1, 32'h0000_0044, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0);

        // Load-use detected while leaving a hold.
        step("hold_lu1", 1'b1, 1'b0, 32'd0, 1'b1, 5'd9, 5'd0, 5'd9, 1'b1);
        step("hold_lu2", 1'b0, 1'b0, 32'd0, 1'b1, 5'd9, 5'd0, 5'd9, 1'b1);

        // Reset during a hold with a branch pending: no flush afterwards.
        step("rst_hold", 1'b1, 1'b1, 32'h0000_0500, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        do_reset(1);
        idle("rst_after1");
        idle("rst_after2");

        // Randomized traffic; small register range makes hazards frequent.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset(1);
            end else begin
                step("rand",
                     ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 5) == 0),
                     $urandom(),
                     1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)));
            end
        end

`ifdef HAZARD_PERF_CNT_EN
        check_counters("rand_end");

        // Preload just below saturation, then two events of each kind.
        force u_dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFE;
        force u_dut.u_flush_cnt.cnt_q = 32'hFFFF_FFFE;
        force u_dut.u_hold_cnt.cnt_q  = 32'hFFFF_FFFE;
        #1;
        release u_dut.u_stall_cnt.cnt_q;
        release u_dut.u_flush_cnt.cnt_q;
        release u_dut.u_hold_cnt.cnt_q;
        m_stall_cnt = 32'hFFFF_FFFE;
        m_flush_cnt = 32'hFFFF_FFFE;
        m_hold_cnt  = 32'hFFFF_FFFE;
        idle("sat_clear");
        for (int k = 0; k < 2; k++) begin
            step("sat_stall", 1'b0, 1'b0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0);
            idle("sat_gap");
            step("sat_hold",  1'b1, 1'b0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
            step("sat_flush", 1'b0, 1'b1, 32'h0000_0ABC, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        end
        check_counters("sat");
        check_eq("sat_stall_ones", Stall_Count, 32'hFFFF_FFFF);
        check_eq("sat_flush_ones", Flush_Count, 32'hFFFF_FFFF);
        check_eq("sat_hold_ones",  Hold_Count,  32'hFFFF_FFFF);

        do_reset(1);
        check_counters("cnt_reset");
`endif

        // ---------------- final report ----------------
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have: rst  input  1  reset; asynchronous, active-high.
REQ-003 SHALL have: IFtoID_Rs, IFtoID_Rt  input  5 each  source register fields of the instruction in ID.
REQ-004 SHALL have: ID_UsesRt  input  1  the ID instruction reads rt.
REQ-005 SHALL have: IDtoEX_MemRead  input  1; IDtoEX_Rt  input  5. Both are taken from the ID/EX register outputs.
REQ-006 SHALL have: MEM_Branch  input  1  one-cycle pulse meaning "branch taken, resolved in MEM"; MEM_BranchTarget  input  32.
REQ-007 SHALL have: MEM_Busy  input  1  data memory wait request.
REQ-008 SHALL have: PCWrite, IFtoID_Write  output  1 each  register enables; 1 = advance.
REQ-009 SHALL have: IDtoEX_Bubble  output  1  zero the control fields loaded into ID/EX.
REQ-010 SHALL have: IFtoID_Flush, IDtoEX_Flush, EXtoMEM_Flush  output  1 each  synchronous clear of those pipe registers.
REQ-011 SHALL have: Pipe_Hold  output  1  freeze all pipe registers; PCSrc_Branch  output  1; BranchTarget_Out  output  32.

Function
REQ-012 SHALL decode a load-use hit (lu) as: IDtoEX_MemRead && IDtoEX_Rt!=0 && (IDtoEX_Rt==IFtoID_Rs || (ID_UsesRt && IDtoEX_Rt==IFtoID_Rt)).
REQ-013 SHALL implement the FSM states RUN, LU_STALL, HOLD; all outputs are combinational (Mealy) from the state, the inputs and the pending-branch register.
REQ-014 SHALL apply priority MEM_Busy > branch > lu in every state.
REQ-015 SHALL, in any state when MEM_Busy=1, drive: Pipe_Hold=1, PCWrite=0, IFtoID_Write=0, flushes=0, PCSrc_Branch=0; next state HOLD.
REQ-016 SHALL, if MEM_Branch=1 while MEM_Busy=1, set the pending flag and latch MEM_BranchTarget; a later pulse during the same hold overwrites the latched target.
REQ-017 SHALL, when MEM_Busy=0 and (MEM_Branch or pending): assert all three flushes, PCSrc_Branch=1, PCWrite=1; drive BranchTarget_Out from MEM_BranchTarget if MEM_Branch=1, else from the latched value. The pending flag clears; next state RUN; lu ignored.
REQ-018 SHALL, in RUN or HOLD with MEM_Busy=0, no branch and lu=1: drive PCWrite=0, IFtoID_Write=0, IDtoEX_Bubble=1; next state LU_STALL.
REQ-019 SHALL, in LU_STALL, suppress lu for that cycle (exactly one stall cycle per load); next state RUN unless REQ-015 or REQ-017 applies.
REQ-020 SHALL otherwise drive PCWrite=1, IFtoID_Write=1, all other outputs 0; next state RUN.
REQ-021 SHALL drive BranchTarget_Out=0 whenever PCSrc_Branch=0.

Reset
REQ-022 SHALL, while rst=1, hold state=RUN, pending=0, latched target=0 and all counters=0.
REQ-023 SHALL, while rst=1, drive every output to 0, including PCWrite and IFtoID_Write.
REQ-024 SHALL discard a pending branch when reset is asserted mid-hold; after release, operation resumes in RUN.

Configuration
REQ-025 SHALL, with HAZARD_PERF_CNT_EN defined, add outputs Stall_Count, Flush_Count, Hold_Count (32 bits each). These increment on lu-stall cycles, branch-flush cycles and MEM_Busy cycles respectively, saturate at 0xFFFFFFFF and clear on reset.
REQ-026 SHALL, without HAZARD_PERF_CNT_EN, have neither those ports nor the counter logic; all other behaviour is identical.

Structure
REQ-027 SHALL take the FSM state encodings, the REG_ZERO (5'd0) constant and the counter width from the shared package mips_pipe_pkg.
REQ-028 SHALL implement the counters with one sub-module, sat_counter (enable, clear, saturating), instantiated three times under the macro.

Verification
REQ-029 SHALL cover: IDtoEX_MemRead=1, IDtoEX_Rt=8, IFtoID_Rs=8 -> one cycle with PCWrite=0, IFtoID_Write=0, IDtoEX_Bubble=1, then LU_STALL, then normal flow.
REQ-030 SHALL cover: the same as REQ-029 but IFtoID_Rt=8 with ID_UsesRt=0, and a separate case with IDtoEX_Rt=0 -> no stall in either.
REQ-031 SHALL cover: MEM_Branch pulse, target 0x0040_0020, MEM_Busy=0 -> same cycle: three flushes=1, PCSrc_Branch=1, BranchTarget_Out=0x0040_0020.
REQ-032 SHALL cover: MEM_Busy=1 for 3 cycles with a MEM_Branch pulse (target 0x100) in cycle 1 -> Pipe_Hold=1 for 3 cycles, then flush with BranchTarget_Out=0x100 in the first non-busy cycle.
REQ-033 SHALL cover: branch and lu in the same cycle -> flush only, no bubble; rst asserted during a hold with a branch pending -> after release, no flush occurs.
REQ-034 SHALL cover, with HAZARD_PERF_CNT_EN: counters preloaded near saturation (force) plus 2 more events -> each holds at 0xFFFFFFFF.
